// File: rtl/load_extend_sequencer_pkg.sv
// Shared definitions for the load/extend sequencer: size codes, FSM states,
// buffer width and small decode helpers.
package load_extend_sequencer_pkg;

  localparam int BUF_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXT  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // Index of the final byte beat for a given access size.
  function automatic logic [1:0] last_beat(input size_e sz);
    case (sz)
      SZ_HALF: last_beat = 2'd1;
      SZ_WORD: last_beat = 2'd3;
      default: last_beat = 2'd0;
    endcase
  endfunction

  // A request is rejected for the reserved size or a misaligned half/word.
  function automatic logic bad_request(input size_e sz, input logic [1:0] lsb);
    case (sz)
      SZ_BYTE: bad_request = 1'b0;
      SZ_HALF: bad_request = lsb[0];
      SZ_WORD: bad_request = |lsb;
      default: bad_request = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_extend_sequencer_if.sv
// Byte-wide data memory read port. The sequencer is the master: it raises
// mem_req with a stable mem_addr until the memory answers with mem_ack.
interface load_extend_sequencer_if #(
  parameter int ADDR_W = 32
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/load_extend_sequencer_width_extender.sv
// Zero/sign extension of the assembled load bytes to a full 32-bit word.
module width_extender
  import load_extend_sequencer_pkg::*;
(
  input  logic [BUF_W-1:0] data_buf,
  input  size_e            size,
  input  logic             is_signed,
  output logic [BUF_W-1:0] result
);

  // Replicate the sign bit of the loaded width, or zero-fill, above it.
  always_comb begin
    result = data_buf;
    case (size)
      SZ_BYTE: result = {{24{is_signed & data_buf[7]}}, data_buf[7:0]};
      SZ_HALF: result = {{16{is_signed & data_buf[15]}}, data_buf[15:0]};
      default: result = data_buf;
    endcase
  end

endmodule

// File: rtl/load_extend_sequencer.sv
// Load sequencer: validates alignment, reads one byte per memory beat,
// assembles them little-endian and hands the word to the extender.
module load_extend_sequencer
  import load_extend_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [1:0]                size,
  input  logic                      is_signed,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [31:0]               result,
  load_extend_sequencer_if.master   mem
);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [BUF_W-1:0]  result_q, result_d;
  logic [ADDR_W-1:0] base_q, base_d;
  size_e             size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [BUF_W-1:0]  ext_value;
  logic              req_bad;
  logic              last_q;

  width_extender u_ext (
    .data_buf  (buf_q),
    .size      (size_q),
    .is_signed (sgn_q),
    .result    (ext_value)
  );

  // Decode the incoming request and the final-beat condition.
  always_comb begin
    req_bad = bad_request(size_e'(size), addr[1:0]);
    last_q  = (idx_q == last_beat(size_q));
  end

  // Control state: FSM, beat index and result register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  // Request latches and byte buffer; only read after being written.
  always_ff @(posedge clk) begin
    base_q <= base_d;
    size_q <= size_d;
    sgn_q  <= sgn_d;
    buf_q  <= buf_d;
  end

  // Next-state logic: accept in IDLE, step through beats, then report.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = req_bad ? ST_ERR : ST_READ;
        end
      end
      ST_READ: begin
        if (mem.mem_ack && last_q) begin
          state_d = ST_EXT;
        end
      end
      ST_EXT:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath updates: latch request, capture bytes into lanes, load result.
  always_comb begin
    idx_d    = idx_q;
    result_d = result_q;
    base_d   = base_q;
    size_d   = size_q;
    sgn_d    = sgn_q;
    buf_d    = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d = addr;
          size_d = size_e'(size);
          sgn_d  = is_signed;
          idx_d  = 2'd0;
        end
      end
      ST_READ: begin
        if (mem.mem_ack) begin
          buf_d[{idx_q, 3'b000} +: 8] = mem.mem_rdata;
          if (!last_q) begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_EXT: begin
        result_d = ext_value;
        idx_d    = 2'd0;
      end
      ST_ERR: begin
        result_d = '0;
      end
      default: ;
    endcase
  end

  // Outputs decoded from state; the beat address wraps modulo 2^ADDR_W.
  always_comb begin
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE) || (state_q == ST_ERR);
    err          = (state_q == ST_ERR);
    result       = (state_q == ST_ERR) ? 32'd0 : result_q;
    mem.mem_req  = (state_q == ST_READ);
    mem.mem_addr = (state_q == ST_READ) ? (base_q + ADDR_W'(idx_q)) : '0;
  end

endmodule

// File: doc/load_extend_sequencer.md
# load_extend_sequencer

Multi-cycle controller that services sub-word and word loads (lb, lbu, lh, lhu, lw) against a byte-wide data memory port. It checks alignment, issues one handshaked byte read per memory beat, assembles the bytes little-endian, then zero- or sign-extends the assembled value to 32 bits. It sits between the processor's load path and data memory, and is the sequencer for the zero/sign extension datapath.

## Interface
Parameters:
- ADDR_W, 32, memory address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  load request; sampled only in IDLE.
- addr  in  ADDR_W  byte address of the load.
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- is_signed  in  1  1 = sign-extend, 0 = zero-extend; ignored for word loads.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; result and err are valid in the same cycle.
- err  out  1  valid with done; high for misalignment or size 11.
- result  out  32  extended load data.
- mem_req  out  1  byte read request to memory.
- mem_addr  out  ADDR_W  byte address of the current beat.
- mem_ack  in  1  memory has accepted the beat; mem_rdata is valid in this cycle.
- mem_rdata  in  8  read byte.

## Operation
- States: IDLE, READ, EXT, DONE, ERR.
- IDLE, start=1:
  - Latch addr, size and is_signed.
  - Error conditions: size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]≠0. Any of these moves to ERR.
  - Otherwise move to READ with beat index idx=0 and nbytes = 1, 2 or 4.
- READ:
  - mem_req=1 and mem_addr = base + idx.
  - On mem_ack, capture mem_rdata into buffer byte lane idx.
  - If idx = nbytes−1, go to EXT; otherwise increment idx and stay in READ.
- EXT:
  - Byte: bits 31:8 = is_signed ? buf[7] : 0.
  - Half: bits 31:16 = is_signed ? buf[15] : 0.
  - Word: pass through unchanged.
  - Write the extended value to the result register, then go to DONE.
- DONE: done=1 and err=0 for one cycle, then go to IDLE.
- ERR: done=1, err=1 and result=0 for one cycle, then go to IDLE. No mem_req is issued.
- start is ignored in every state except IDLE; no request is queued.
- result holds its value until the next EXT or ERR state.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, busy=0, done=0, err=0, result=0, mem_req=0, mem_addr=0, idx=0.
- Request acceptance: start is accepted at edge t; busy=1 and mem_req=1 from cycle t+1.
- Minimum latency with mem_ack high on every beat: done at t+2+nbytes (byte t+3, half t+4, word t+6).
- Error latency: done and err at t+1.
- Memory handshake:
  - mem_req may stay high across consecutive beats.
  - mem_addr changes only on the edge after mem_ack.
  - mem_addr is held stable while mem_req=1 and mem_ack=0.
  - Wait cycles are unbounded; there is no timeout.
- mem_ack outside READ is ignored.
- Back-to-back loads: the earliest next start is accepted in the IDLE cycle after DONE/ERR; a start coinciding with done is ignored.
- Reset during READ: mem_req drops immediately and the outstanding beat is abandoned. The memory side must tolerate a dropped request.
- Address arithmetic: base + idx is computed modulo 2^ADDR_W. Aligned accesses never cross a wrap, so 0xFFFFFFFF is a legal byte load.

## Structure
- Shared package holds:
  - size encodings: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - the state enum;
  - a localparam for the buffer width (32).
- One combinational sub-module, width_extender (inputs: 32-bit buf, size, is_signed; output: 32-bit result), is used in EXT.
- All remaining logic (FSM, idx counter, byte buffer, result register) lives in load_extend_sequencer.

## Test plan
- lbu at 0x00001003, mem_rdata=0x80 with immediate ack -> single beat to 0x1003; done at t+3; result=0x00000080; err=0.
- lb at 0x00001003, mem_rdata=0x80 -> result=0xFFFFFF80.
- lh signed at 0x2000, bytes 0x34 then 0x92, ack delayed 2 cycles per beat -> mem_addr holds 0x2000 then 0x2001 while stalled; result=0xFFFF9234. The same load as lhu -> result=0x00009234.
- lw at 0x3000, bytes 0xEF, 0xBE, 0xAD, 0xDE -> result=0xDEADBEEF; done at t+6 with zero-wait acks.
- lw at 0x2002, lh at 0x2001, and size=11 -> each gives done and err at t+1, result=0x00000000, and mem_req never asserted. A start pulsed during busy -> ignored, with no extra beat issued.
- rst_n low during the third beat of a word load -> mem_req, busy and result go to 0 immediately. After release, lbu at 0x0 with byte 0x7F completes normally with result=0x0000007F.
